// File: rtl/pipe_stage_bank.sv
//==============================================================================
// Module  : pipe_stage_bank
// Purpose : Elastic bank of STAGES pipeline registers with valid/ready
//           handshake, bubble collapse and flush. PIPE_SKID_EN adds a skid entry.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module pipe_stage_bank #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 160,
  parameter int STAGES = 1,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [STAGES-1:0] slot_valid,
  output logic [CNT_W-1:0]  count
);

  logic [STAGES-1:0]             r_v;
  logic [STAGES-1:0][CTRL_W-1:0] r_c;
  logic [STAGES-1:0][DATA_W-1:0] r_d;
  logic [CNT_W-1:0]              r_cnt;

  logic [STAGES-1:0]             w_rdy;
  logic [STAGES-1:0]             w_sv;
  logic [STAGES-1:0][CTRL_W-1:0] w_sc;
  logic [STAGES-1:0][DATA_W-1:0] w_sd;

  logic              w_src_v;
  logic [CTRL_W-1:0] w_src_c;
  logic [DATA_W-1:0] w_src_d;
  logic              w_in_hs;
  logic              w_out_hs;

  // A slot can advance when downstream takes its entry or any slot from it
  // to the output is empty (bubble collapse).
  always_comb begin
    w_rdy = '0;
    for (int i = 0; i < STAGES; i++) begin
      logic w_full;
      w_full = 1'b1;
      for (int j = i; j < STAGES; j++) begin
        w_full = w_full & r_v[j];
      end
      w_rdy[i] = out_ready | ~w_full;
    end
  end

`ifdef PIPE_SKID_EN
  logic              r_skid_full;
  logic [CTRL_W-1:0] r_skid_c;
  logic [DATA_W-1:0] r_skid_d;

  // in_ready depends only on registered state and flush, not on out_ready.
  assign in_ready = ~r_skid_full & ~flush;
  assign w_src_v  = r_skid_full | in_valid;
  assign w_src_c  = r_skid_full ? r_skid_c : in_ctrl;
  assign w_src_d  = r_skid_full ? r_skid_d : in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_full <= 1'b0;
      r_skid_c    <= '0;
      r_skid_d    <= '0;
    end else if (flush) begin
      r_skid_full <= 1'b0;
      r_skid_c    <= '0;
    end else if (r_skid_full) begin
      if (w_rdy[0]) begin
        r_skid_full <= 1'b0;
        r_skid_c    <= '0;
      end
    end else if (in_valid && !w_rdy[0]) begin
      r_skid_full <= 1'b1;
      r_skid_c    <= in_ctrl;
      r_skid_d    <= in_data;
    end
  end
`else
  assign in_ready = w_rdy[0] & ~flush;
  assign w_src_v  = in_valid;
  assign w_src_c  = in_ctrl;
  assign w_src_d  = in_data;
`endif

  always_comb begin
    w_sv    = '0;
    w_sc    = '0;
    w_sd    = '0;
    w_sv[0] = w_src_v;
    w_sc[0] = w_src_c;
    w_sd[0] = w_src_d;
    for (int i = 1; i < STAGES; i++) begin
      w_sv[i] = r_v[i-1];
      w_sc[i] = r_c[i-1];
      w_sd[i] = r_d[i-1];
    end
  end

  // Data is only captured from a valid source so stale payloads never leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      r_c <= '0;
      r_d <= '0;
    end else if (flush) begin
      r_v <= '0;
      r_c <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (w_rdy[i]) begin
          r_v[i] <= w_sv[i];
          r_c[i] <= w_sv[i] ? w_sc[i] : '0;
          if (w_sv[i]) begin
            r_d[i] <= w_sd[i];
          end
        end
      end
    end
  end

  assign w_in_hs  = in_valid & in_ready;
  assign w_out_hs = r_v[STAGES-1] & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_in_hs && !w_out_hs) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (!w_in_hs && w_out_hs) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign out_valid  = r_v[STAGES-1];
  assign out_ctrl   = r_c[STAGES-1];
  assign out_data   = r_d[STAGES-1];
  assign slot_valid = r_v;
  assign count      = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_bank.sv
//==============================================================================
// Module  : tb_pipe_stage_bank
// Purpose : Scoreboard bench for pipe_stage_bank (directed + random traffic).
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pipe_stage_bank;
  localparam int CTRL_W = 16;
  localparam int DATA_W = 160;
  localparam int STAGES = 3;
  localparam int CNT_W  = 4;
`ifdef PIPE_SKID_EN
  localparam int CAP  = STAGES + 1;
  localparam bit SKID = 1'b1;
`else
  localparam int CAP  = STAGES;
  localparam bit SKID = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [STAGES-1:0] slot_valid;
  logic [CNT_W-1:0]  count;

  pipe_stage_bank #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .STAGES(STAGES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .slot_valid(slot_valid), .count(count)
  );

  typedef struct {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
    int                acc;
  } ent_t;

  ent_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   lat_chk = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_d();
    logic [DATA_W-1:0] v;
    v = '0;
    for (int k = 0; k < DATA_W / 32; k++) v = {v[DATA_W-33:0], 32'($urandom)};
    return v;
  endfunction

  // Monitor: the model is an ordered list of accepted entries; the bank's
  // occupancy, readiness and head entry follow from it.
  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_ir;
      chk("count", count, sb.size());
      exp_ir = !flush && ((sb.size() < CAP) || (!SKID && out_ready));
      chk("in_ready", in_ready, exp_ir);
      if (!out_valid) begin
        chk("out_ctrl_idle", out_ctrl, 0);
      end else if (sb.size() == 0) begin
        chk("out_valid_unexpected", out_valid, 0);
      end else begin
        chk("out_ctrl", out_ctrl, sb[0].c);
        chk("out_data", out_data, sb[0].d);
        if (out_ready) begin
          if (lat_chk) chk("latency", cyc - sb[0].acc, STAGES);
          void'(sb.pop_front());
        end
      end
      if (flush) sb.delete();
    end
  end

  // One cycle of stimulus; called just after a rising edge.
  task automatic step(input bit iv, input logic [CTRL_W-1:0] ic, input logic [DATA_W-1:0] id,
                      input bit orr, input bit fl, output bit took);
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = id;
    out_ready = orr;
    flush     = fl;
    @(negedge clk);
    #1;
    took = in_valid && in_ready;
    if (took) sb.push_back('{c: ic, d: id, acc: cyc});
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    bit t;
    for (int k = 0; k < 40 && (sb.size() != 0 || count != 0); k++) step(0, '0, '0, 1, 0, t);
    chk(name, sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit t;
    logic [DATA_W-1:0] d1;
    rst_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_count", count, 0);
    chk("rst_slot_valid", slot_valid, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Streaming with constant latency and no gaps
    lat_chk = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1, CTRL_W'(k), DATA_W'(9 + k), 1, 0, t);
      chk("stream_accept", t, 1);
    end
    drain("stream_drain");
    lat_chk = 1'b0;

    // Backpressure: fill to capacity, next offer refused
    for (int k = 0; k <= CAP; k++) begin
      step(1, CTRL_W'(16 + k), rnd_d(), 0, 0, t);
      chk("bp_accept", t, (k < CAP));
    end
    chk("bp_count", count, CAP);
    chk("bp_slot_valid", slot_valid, {STAGES{1'b1}});
    chk("bp_in_ready", in_ready, 0);
`ifdef PIPE_SKID_EN
    out_ready = 1'b1;
    #1;
    chk("skid_in_ready_reg", in_ready, 0);
`endif
    t = 1'b0;
    for (int k = 0; k < 6 && !t; k++) step(1, in_ctrl, in_data, 1, 0, t);
    chk("bp_late_accept", t, 1);
    drain("bp_drain");

    // Bubble collapse then flush
    d1 = rnd_d();
    step(1, 16'h0021, d1, 0, 0, t);
    step(0, '0, '0, 0, 0, t);
    step(0, '0, '0, 0, 0, t);
    step(1, 16'h0022, rnd_d(), 0, 0, t);
    chk("bubble_accept", t, 1);
    step(0, '0, '0, 0, 0, t);
    chk("bubble_slots", slot_valid, 3'b110);
    chk("bubble_count", count, 2);
    step(1, 16'h0023, rnd_d(), 0, 1, t);
    chk("flush_refuse", t, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_ctrl", out_ctrl, 0);
    chk("flush_count", count, 0);
    chk("flush_slots", slot_valid, 0);
    chk("flush_data_hold", out_data, d1);

    // Asynchronous reset with entries held
    step(1, 16'h0031, rnd_d(), 0, 0, t);
    step(1, 16'h0032, rnd_d(), 0, 0, t);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_ctrl", out_ctrl, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_count", count, 0);
    sb.delete();
    #1 rst_n = 1'b1;

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      step(($urandom % 4) != 0, CTRL_W'($urandom), rnd_d(), ($urandom % 3) != 0,
           ($urandom % 25) == 0, t);
    end
    drain("rand_drain");
    chk("final_count", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_stage_bank.md
Name: pipe_stage_bank

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (ID/EXE style).
- Carries a control field (write-enables, mux selects, ALU op) and a data field (operands, immediate, instruction, PC) through STAGES elastic register slots.
- Adds a valid/ready handshake, bubble collapse and synchronous flush.
- Used between any two pipeline stages. The hazard unit drives flush; the downstream stage drives out_ready to stall.

Parameters:
- CTRL_W, 16, width of the control field; forced to zero in empty slots and on flush.
- DATA_W, 160, width of the data field; never cleared except by reset.
- STAGES, 1, number of register slots in series; legal range 1..8.
- CNT_W, 4, width of the occupancy counter; must hold STAGES+1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents an entry.
- in_ready  output  1  bank accepts the entry this cycle.
- in_ctrl  input  CTRL_W  control field of the incoming entry.
- in_data  input  DATA_W  data field of the incoming entry.
- flush  input  1  synchronous kill of all held entries.
- out_valid  output  1  last slot holds an entry.
- out_ready  input  1  downstream consumes the entry this cycle.
- out_ctrl  output  CTRL_W  control field of the last slot; 0 when out_valid=0.
- out_data  output  DATA_W  data field of the last slot.
- slot_valid  output  STAGES  per-slot valid bits; bit 0 is the input slot.
- count  output  CNT_W  number of valid entries held.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all slot valid bits, ctrl and data registers, and count go to 0.
  - out_valid=0, out_ctrl=0, out_data=0, slot_valid=0.
  - in_ready=1 once rst_n is released (no skid variant).
- Slot i state: valid v[i], ctrl c[i], data d[i].
- Ready chain:
  - r[STAGES-1] = out_ready | ~v[STAGES-1].
  - r[i] = r[i+1] | ~v[i].
  - Bubble collapse: an empty slot always accepts, even if downstream is stalled.
- Transfers:
  - Slot i loads from slot i-1 (slot 0 from the input) when r[i]=1.
  - Loaded v[i] = v[i-1] (in_valid for slot 0).
  - Loaded c[i] = source ctrl if the source is valid, else 0.
  - d[i] loads the source data only when the source is valid; otherwise it holds.
  - Invariant: v[i]=0 implies c[i]=0.
- in_ready = r[0] & ~flush.
- Input handshake occurs when in_valid & in_ready. Output handshake occurs when out_valid & out_ready.
- Latency: an entry accepted at edge N appears on out_* after edge N+STAGES-1 (visible in cycle N+STAGES-1) when nothing is stalled.
- Throughput: 1 entry per cycle sustained.
- Stall: with out_ready=0, a full slot holds ctrl and data unchanged indefinitely. Upstream slots keep collapsing bubbles until every slot is full, then in_ready=0.
- Flush: at the next edge all v and c clear to 0; d holds.
  - Flush has priority over simultaneous input and output handshakes.
  - The input is not accepted (in_ready=0).
  - out_ready in the flush cycle still qualifies an output handshake already presented: the downstream may consume it, and the bank then drops it.
- count: +1 on input handshake, -1 on output handshake, unchanged when both occur; forced to 0 on flush. Never exceeds STAGES.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.

Optional Feature:
- Macro: PIPE_SKID_EN.
- Defined:
  - Adds a one-entry skid register ahead of slot 0.
  - in_ready becomes a registered signal (= ~skid_full), removing the combinational path from out_ready to in_ready.
  - Capacity becomes STAGES+1; count includes the skid entry.
  - Latency rises by 1 only when the skid entry is in use.
  - Flush also clears the skid entry.
  - in_ready resets to 1.
- Undefined: no skid register; in_ready is combinational as above; capacity is STAGES.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with entries held -> out_valid=0, out_ctrl=0, out_data=0, count=0 immediately, before the next edge.
- Streaming, STAGES=3, out_ready=1: inputs ctrl=0x0001..0x0004, data=0xA..0xD on consecutive cycles -> the same values appear on out_* three edges later, one per cycle, with no gaps.
- Backpressure, STAGES=3, out_ready=0: offer 4 entries -> first 3 accepted, in_ready=0 on the 4th, count=3, slot_valid=3'b111. Raise out_ready -> entries drain in order and the 4th is accepted.
- Bubble collapse, STAGES=3: send 1 entry, hold out_ready=0 two cycles, then send a 2nd -> both present with slot_valid=3'b110 within 2 edges, with no overwrite.
- Flush with in_valid=1 and count=2 -> next cycle out_valid=0, out_ctrl=0, count=0, and the input entry was not accepted.
- PIPE_SKID_EN, STAGES=2, out_ready=0: offer 4 entries -> 3 accepted and count=3. Toggling out_ready does not change in_ready in the same cycle.
